// File: rtl/car_request_latch_if.sv
// Sensor/lights bundle between the board pins, the intersection controller and car_request_latch.
// The master side drives sensor_raw and lights; the slave side (the latch) returns car, lights_fault and wait_cycles.
interface car_request_latch_if #(
    parameter int WAIT_W = 32
);
    logic              sensor_raw;
    logic [6:0]        lights;
    logic              car;
    logic              lights_fault;
    logic [WAIT_W-1:0] wait_cycles;

    modport master (
        output sensor_raw,
        output lights,
        input  car,
        input  lights_fault,
        input  wait_cycles
    );

    modport slave (
        input  sensor_raw,
        input  lights,
        output car,
        output lights_fault,
        output wait_cycles
    );
endinterface

// File: rtl/car_request_latch.sv
// East/west vehicle request latch: synchronize, debounce, latch until EW green, fail safe on bad lights.
// Optional wait-time counter enabled by defining CAR_WAIT_STATS_EN.
//
// state  | meaning
// IDLE   | no request outstanding, car=0
// REQ    | request latched, car=1 until EW green seen
// SERVED | EW green seen, car=0 until NS green returns
// FAULT  | illegal lights persisted, car=0, exits only on reset
module car_request_latch #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FAULT_CYCLES    = 4,
    parameter int WAIT_W          = 32
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    car_request_latch_if.slave bus
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FC_W = (FAULT_CYCLES > 1) ? $clog2(FAULT_CYCLES + 1) : 1;

    localparam logic [5:0] L_GNS = 6'b100001;
    localparam logic [5:0] L_YNS = 6'b010001;
    localparam logic [5:0] L_GEW = 6'b001100;
    localparam logic [5:0] L_YEW = 6'b001010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SERVED = 2'd2,
        FAULT  = 2'd3
    } state_e;

    logic            s1_q, s2_q;
    logic            deb_q, deb_d;
    logic [DB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [FC_W-1:0] fault_cnt_q, fault_cnt_d;
    state_e          state_q, state_d;
    logic            car_q, car_d;
    logic            lights_legal, fault_hit;
    logic [5:0]      lights6;
    logic            unused_lights_bit6;

    assign lights6            = bus.lights[5:0];
    assign unused_lights_bit6 = bus.lights[6];

    assign lights_legal = (lights6 == L_GNS) || (lights6 == L_YNS) ||
                          (lights6 == L_GEW) || (lights6 == L_YEW);
    assign fault_hit    = !lights_legal && (fault_cnt_q == FC_W'(FAULT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            deb_q       <= 1'b0;
            deb_cnt_q   <= '0;
            fault_cnt_q <= '0;
            state_q     <= IDLE;
            car_q       <= 1'b0;
        end else begin
            s1_q        <= bus.sensor_raw;
            s2_q        <= s1_q;
            deb_q       <= deb_d;
            deb_cnt_q   <= deb_cnt_d;
            fault_cnt_q <= fault_cnt_d;
            state_q     <= state_d;
            car_q       <= car_d;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (s2_q != deb_q) begin
            if (deb_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        fault_cnt_d = fault_cnt_q;
        if (lights_legal) begin
            fault_cnt_d = '0;
        end else if (!fault_hit) begin
            fault_cnt_d = fault_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (deb_q && lights6 == L_GNS) state_d = REQ;
            REQ:     if (lights6 == L_GEW)          state_d = SERVED;
            SERVED:  if (lights6 == L_GNS)          state_d = IDLE;
            FAULT:   state_d = FAULT;
            default: state_d = FAULT;
        endcase
        if (fault_hit) begin
            state_d = FAULT;
        end
        car_d = (state_d == REQ);
    end

    assign bus.car          = car_q;
    assign bus.lights_fault = (state_q == FAULT);

`ifdef CAR_WAIT_STATS_EN
    logic [WAIT_W-1:0] wait_q, wait_d;

    always_comb begin
        wait_d = wait_q;
        if (state_q == IDLE && state_d == REQ) begin
            wait_d = '0;
        end else if (state_q == REQ && wait_q != {WAIT_W{1'b1}}) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign bus.wait_cycles = wait_q;
`else
    assign bus.wait_cycles = {WAIT_W{1'b0}};
`endif
endmodule

// File: tb/tb_car_request_latch.sv
// Directed bench for car_request_latch with DEBOUNCE_CYCLES=4, FAULT_CYCLES=4, WAIT_W=3.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
module tb_car_request_latch;
    localparam logic [6:0] GNS   = 7'b0100001;
    localparam logic [6:0] GNS_B = 7'b1100001;
    localparam logic [6:0] YNS   = 7'b0010001;
    localparam logic [6:0] GEW   = 7'b0001100;
    localparam logic [6:0] YEW   = 7'b0001010;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    car_request_latch_if #(.WAIT_W(3)) bus ();

    car_request_latch #(
        .DEBOUNCE_CYCLES(4),
        .FAULT_CYCLES   (4),
        .WAIT_W         (3)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_wait(input string tag, input logic [2:0] exp_en);
`ifdef CAR_WAIT_STATS_EN
        check(tag, 32'(bus.wait_cycles), 32'(exp_en));
`else
        check(tag, 32'(bus.wait_cycles), 32'd0);
`endif
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset_n        = 1'b0;
        bus.sensor_raw = 1'b0;
        bus.lights     = GNS;
        tick(2);
        check("reset_car", 32'(bus.car), 32'd0);
        check("reset_fault", 32'(bus.lights_fault), 32'd0);
        check_wait("reset_wait", 3'd0);
        reset_n = 1'b1;

        // Short pulse: 3 cycles high is not enough to debounce.
        bus.sensor_raw = 1'b1;
        tick(3);
        bus.sensor_raw = 1'b0;
        tick(8);
        check("glitch_no_car", 32'(bus.car), 32'd0);

        // Held sensor: car rises after edge 7, not edge 6.
        bus.sensor_raw = 1'b1;
        tick(6);
        check("latency_edge6", 32'(bus.car), 32'd0);
        tick(1);
        check("latency_edge7", 32'(bus.car), 32'd1);
        check_wait("wait_clear_on_req", 3'd0);

        // Vehicle leaves while waiting: request stays latched, wait counter saturates.
        bus.sensor_raw = 1'b0;
        tick(10);
        check("req_held_after_leave", 32'(bus.car), 32'd1);
        check_wait("wait_saturated", 3'd7);
        bus.lights = YNS;
        tick(1);
        check("req_held_yns", 32'(bus.car), 32'd1);
        bus.lights = GEW;
        tick(1);
        check("served_on_gew", 32'(bus.car), 32'd0);
        check_wait("wait_hold_served", 3'd7);
        bus.lights = YEW;
        tick(1);
        bus.lights = GNS;
        tick(2);
        check("idle_no_rerequest", 32'(bus.car), 32'd0);
        check_wait("wait_hold_idle", 3'd7);

        // Vehicle present through a whole cycle re-requests two edges after GNS.
        bus.sensor_raw = 1'b1;
        tick(7);
        check("second_request", 32'(bus.car), 32'd1);
        bus.lights = YNS;
        tick(1);
        bus.lights = GEW;
        tick(1);
        check("second_served", 32'(bus.car), 32'd0);
        bus.lights = YEW;
        tick(1);
        bus.lights = GNS;
        tick(1);
        check("rereq_edge1_idle", 32'(bus.car), 32'd0);
        tick(1);
        check("rereq_edge2_req", 32'(bus.car), 32'd1);
        check_wait("wait_clear_rereq", 3'd0);

        // Three illegal cycles then legal: no fault.
        bus.lights = 7'b0111111;
        tick(3);
        bus.lights = GNS;
        tick(1);
        check("fault3_no_fault", 32'(bus.lights_fault), 32'd0);
        check("fault3_car_held", 32'(bus.car), 32'd1);

        // Four illegal cycles: fault latches on the 4th edge.
        bus.lights = 7'b0000000;
        tick(3);
        check("fault_edge3_none", 32'(bus.lights_fault), 32'd0);
        tick(1);
        check("fault_edge4_set", 32'(bus.lights_fault), 32'd1);
        check("fault_edge4_car", 32'(bus.car), 32'd0);
        bus.lights = GNS;
        tick(3);
        check("fault_sticky", 32'(bus.lights_fault), 32'd1);
        check("fault_car_low", 32'(bus.car), 32'd0);
        reset_n = 1'b0;
        tick(1);
        check("fault_reset_clear", 32'(bus.lights_fault), 32'd0);
        check("fault_reset_car", 32'(bus.car), 32'd0);
        check_wait("fault_reset_wait", 3'd0);

        // Request waits in IDLE while NS is not green; bit6 of lights is ignored.
        bus.lights = YNS;
        reset_n    = 1'b1;
        tick(10);
        check("wait_in_idle_yns", 32'(bus.car), 32'd0);
        bus.lights = GEW;
        tick(2);
        check("wait_in_idle_gew", 32'(bus.car), 32'd0);
        bus.lights = GNS_B;
        tick(1);
        check("req_on_gns_bit6", 32'(bus.car), 32'd1);
        check("no_fault_bit6", 32'(bus.lights_fault), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
